alu_cmd_issuer: RTL and testbench

- Initiator side of the ALU operation interface. Accepts one command (function code plus two operands) over a valid/ready handshake.
- Issues the command to the ALU as a single-cycle enable pulse, then waits for the ALU's registered result/valid.
- Returns the captured result as a stream of DATA_W-wide bytes, least significant first, to the TX path.
- Sits between the system controller command decoder and the ALU / TX FIFO.

---
 rtl/alu_cmd_issuer.sv | 163 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command initiator for the ALU: latches one command, pulses ALU_EN, captures the result
// and streams it LSB-byte first to TX. Optional ALU_TIMEOUT_EN adds a WAIT watchdog with ERR.
module alu_cmd_issuer #(
  parameter int DATA_W  = 8,
  parameter int FUN_W   = 4,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [FUN_W-1:0]  CMD_FUN,
  input  logic [DATA_W-1:0] CMD_A,
  input  logic [DATA_W-1:0] CMD_B,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              ALU_EN,
  input  logic [RES_W-1:0]  ALU_OUT,
  input  logic              ALU_OUT_VALID,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic              BUSY,
  output logic              ERR
);

  // state  | meaning
  // IDLE   | ready for a command
  // ISSUE  | ALU_EN pulse cycle
  // WAIT   | waiting for ALU_OUT_VALID
  // SEND   | streaming result bytes to TX

  localparam int NBYTES = RES_W / DATA_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
  logic [RES_W-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                expire;

`ifdef ALU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q;

  // Expiry is decided in the last permitted WAIT cycle so ERR lands on the first SEND cycle.
  assign expire = (state_q == S_WAIT) && !ALU_OUT_VALID &&
                  (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_ISSUE) begin
      tmo_d = '0;
    end else if ((state_q == S_WAIT) && !ALU_OUT_VALID) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= expire;
    end
  end

  assign ERR = err_q;
`else
  assign expire = 1'b0;
  assign ERR    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          alu_a_d   = CMD_A;
          alu_b_d   = CMD_B;
          alu_fun_d = CMD_FUN;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A real result in the expiry cycle takes priority over the error fill.
        if (ALU_OUT_VALID) begin
          shift_d = ALU_OUT;
          cnt_d   = LAST_CNT;
          state_d = S_SEND;
        end else if (expire) begin
          shift_d = '1;
          cnt_d   = LAST_CNT;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (TX_READY) begin
          shift_d = shift_q >> DATA_W;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= S_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
    end
  end

  assign CMD_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign ALU_EN    = (state_q == S_ISSUE);
  assign TX_VALID  = (state_q == S_SEND);
  assign TX_DATA   = shift_q[DATA_W-1:0];
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: table-driven transactions plus hand sequences
// for reset abort, busy back-pressure, stray ALU valid and the no-response case.
module tb_alu_cmd_issuer;

  localparam int DATA_W  = 8;
  localparam int FUN_W   = 4;
  localparam int RES_W   = 16;
  localparam int TIMEOUT = 15;

  logic              CLK = 1'b0;
  logic              RST_n = 1'b0;
  logic              CMD_VALID = 1'b0;
  logic              CMD_READY;
  logic [FUN_W-1:0]  CMD_FUN = '0;
  logic [DATA_W-1:0] CMD_A = '0;
  logic [DATA_W-1:0] CMD_B = '0;
  logic [DATA_W-1:0] ALU_A;
  logic [DATA_W-1:0] ALU_B;
  logic [FUN_W-1:0]  ALU_FUN;
  logic              ALU_EN;
  logic [RES_W-1:0]  ALU_OUT = '0;
  logic              ALU_OUT_VALID = 1'b0;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_READY = 1'b0;
  logic              BUSY;
  logic              ERR;

  alu_cmd_issuer #(
    .DATA_W(DATA_W), .FUN_W(FUN_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST_n(RST_n),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_FUN(CMD_FUN), .CMD_A(CMD_A), .CMD_B(CMD_B),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;

  always @(posedge CLK) if (ALU_EN === 1'b1) en_cnt <= en_cnt + 1;

  typedef struct {
    logic [3:0]  fun;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    int          stall;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic run_vec(input vec_t v);
    int en0;
    en0 = en_cnt;
    CMD_VALID = 1'b1; CMD_FUN = v.fun; CMD_A = v.a; CMD_B = v.b;
    chk("vec_cmd_ready_idle", 32'(CMD_READY), 32'd1);
    cyc();
    CMD_VALID = 1'b0;
    chk("vec_alu_en_issue", 32'(ALU_EN), 32'd1);
    chk("vec_alu_a", 32'(ALU_A), 32'(v.a));
    chk("vec_alu_b", 32'(ALU_B), 32'(v.b));
    chk("vec_alu_fun", 32'(ALU_FUN), 32'(v.fun));
    chk("vec_cmd_ready_busy", 32'(CMD_READY), 32'd0);
    cyc();
    chk("vec_alu_en_drop", 32'(ALU_EN), 32'd0);
    chk("vec_tx_valid_wait", 32'(TX_VALID), 32'd0);
    ALU_OUT = v.res; ALU_OUT_VALID = 1'b1;
    cyc();
    ALU_OUT_VALID = 1'b0; ALU_OUT = '0;
    chk("vec_tx_valid_lat3", 32'(TX_VALID), 32'd1);
    chk("vec_byte0", 32'(TX_DATA), 32'(v.exp0));
    for (int i = 0; i < v.stall; i++) begin
      TX_READY = 1'b0;
      cyc();
      chk("vec_byte0_hold", 32'(TX_DATA), 32'(v.exp0));
      chk("vec_valid_hold", 32'(TX_VALID), 32'd1);
    end
    TX_READY = 1'b1;
    cyc();
    chk("vec_byte1", 32'(TX_DATA), 32'(v.exp1));
    chk("vec_busy_b1", 32'(BUSY), 32'd1);
    chk("vec_alu_a_held", 32'(ALU_A), 32'(v.a));
    cyc();
    TX_READY = 1'b0;
    chk("vec_tx_valid_done", 32'(TX_VALID), 32'd0);
    chk("vec_busy_done", 32'(BUSY), 32'd0);
    chk("vec_cmd_ready_done", 32'(CMD_READY), 32'd1);
    chk("vec_en_pulses", 32'(en_cnt - en0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0;
    vecs[0] = '{fun: 4'h0, a: 8'h12, b: 8'h34, res: 16'h0046, stall: 0, exp0: 8'h46, exp1: 8'h00};
    vecs[1] = '{fun: 4'h1, a: 8'hFF, b: 8'h01, res: 16'hABCD, stall: 5, exp0: 8'hCD, exp1: 8'hAB};
    vecs[2] = '{fun: 4'h2, a: 8'hA5, b: 8'h5A, res: 16'hFFFF, stall: 1, exp0: 8'hFF, exp1: 8'hFF};
    vecs[3] = '{fun: 4'h7, a: 8'h00, b: 8'h00, res: 16'h0000, stall: 2, exp0: 8'h00, exp1: 8'h00};
    vecs[4] = '{fun: 4'hF, a: 8'h7F, b: 8'h81, res: 16'h1234, stall: 0, exp0: 8'h34, exp1: 8'h12};

    // reset state
    cyc(); cyc();
    chk("rst_alu_a", 32'(ALU_A), 32'd0);
    chk("rst_alu_fun", 32'(ALU_FUN), 32'd0);
    chk("rst_alu_en", 32'(ALU_EN), 32'd0);
    chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    RST_n = 1'b1;
    cyc();
    chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("rst_tx_data", 32'(TX_DATA), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // stray ALU_OUT_VALID while idle
    ALU_OUT = 16'h1234; ALU_OUT_VALID = 1'b1;
    cyc();
    ALU_OUT_VALID = 1'b0; ALU_OUT = '0;
    chk("stray_busy", 32'(BUSY), 32'd0);
    chk("stray_tx_valid", 32'(TX_VALID), 32'd0);
    cyc();
    chk("stray_tx_valid2", 32'(TX_VALID), 32'd0);
    chk("stray_cmd_ready", 32'(CMD_READY), 32'd1);

    // second command held while busy
    en0 = en_cnt;
    CMD_VALID = 1'b1; CMD_FUN = 4'h3; CMD_A = 8'h11; CMD_B = 8'h22;
    cyc();
    CMD_FUN = 4'h5; CMD_A = 8'h55; CMD_B = 8'h66;
    chk("bb_alu_en", 32'(ALU_EN), 32'd1);
    cyc();
    chk("bb_cmd_ready_wait", 32'(CMD_READY), 32'd0);
    chk("bb_alu_a_wait", 32'(ALU_A), 32'h11);
    ALU_OUT = 16'h0102; ALU_OUT_VALID = 1'b1;
    cyc();
    ALU_OUT_VALID = 1'b0;
    TX_READY = 1'b1;
    chk("bb_byte0", 32'(TX_DATA), 32'h02);
    chk("bb_cmd_ready_send", 32'(CMD_READY), 32'd0);
    cyc();
    chk("bb_byte1", 32'(TX_DATA), 32'h01);
    chk("bb_alu_fun_send", 32'(ALU_FUN), 32'h3);
    cyc();
    TX_READY = 1'b0;
    chk("bb_idle_ready", 32'(CMD_READY), 32'd1);
    chk("bb_idle_alu_a", 32'(ALU_A), 32'h11);
    chk("bb_en_count1", 32'(en_cnt - en0), 32'd1);
    cyc();
    CMD_VALID = 1'b0;
    chk("bb_second_en", 32'(ALU_EN), 32'd1);
    chk("bb_second_a", 32'(ALU_A), 32'h55);
    chk("bb_second_fun", 32'(ALU_FUN), 32'h5);
    cyc();
    ALU_OUT = 16'h00FF; ALU_OUT_VALID = 1'b1;
    cyc();
    ALU_OUT_VALID = 1'b0;
    TX_READY = 1'b1;
    chk("bb2_byte0", 32'(TX_DATA), 32'hFF);
    cyc();
    chk("bb2_byte1", 32'(TX_DATA), 32'h00);
    cyc();
    TX_READY = 1'b0;
    chk("bb2_idle", 32'(BUSY), 32'd0);
    chk("bb_en_count2", 32'(en_cnt - en0), 32'd2);

    // reset while streaming
    CMD_VALID = 1'b1; CMD_FUN = 4'h9; CMD_A = 8'h3C; CMD_B = 8'hC3;
    cyc();
    CMD_VALID = 1'b0;
    cyc();
    ALU_OUT = 16'hBEEF; ALU_OUT_VALID = 1'b1;
    cyc();
    ALU_OUT_VALID = 1'b0;
    chk("rs_tx_valid_pre", 32'(TX_VALID), 32'd1);
    chk("rs_byte0_pre", 32'(TX_DATA), 32'hEF);
    RST_n = 1'b0;
    #1;
    chk("rs_tx_valid", 32'(TX_VALID), 32'd0);
    chk("rs_busy", 32'(BUSY), 32'd0);
    chk("rs_alu_a", 32'(ALU_A), 32'd0);
    chk("rs_alu_b", 32'(ALU_B), 32'd0);
    chk("rs_alu_fun", 32'(ALU_FUN), 32'd0);
    chk("rs_alu_en", 32'(ALU_EN), 32'd0);
    cyc();
    RST_n = 1'b1;
    TX_READY = 1'b1;
    cyc();
    chk("rs_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("rs_no_resume", 32'(TX_VALID), 32'd0);
    TX_READY = 1'b0;

    // ALU never answers
    CMD_VALID = 1'b1; CMD_FUN = 4'h6; CMD_A = 8'h01; CMD_B = 8'h02;
    cyc();
    CMD_VALID = 1'b0;
    cyc();
`ifdef ALU_TIMEOUT_EN
    for (int w = 1; w <= TIMEOUT; w++) begin
      chk("tmo_err_low", 32'(ERR), 32'd0);
      chk("tmo_wait_tx", 32'(TX_VALID), 32'd0);
      cyc();
    end
    chk("tmo_err_pulse", 32'(ERR), 32'd1);
    chk("tmo_tx_valid", 32'(TX_VALID), 32'd1);
    chk("tmo_byte0", 32'(TX_DATA), 32'hFF);
    TX_READY = 1'b1;
    cyc();
    chk("tmo_err_once", 32'(ERR), 32'd0);
    chk("tmo_byte1", 32'(TX_DATA), 32'hFF);
    cyc();
    TX_READY = 1'b0;
    chk("tmo_idle", 32'(BUSY), 32'd0);
    chk("tmo_ready", 32'(CMD_READY), 32'd1);
`else
    for (int w = 0; w < 30; w++) cyc();
    chk("nr_busy", 32'(BUSY), 32'd1);
    chk("nr_tx_valid", 32'(TX_VALID), 32'd0);
    chk("nr_err", 32'(ERR), 32'd0);
    chk("nr_cmd_ready", 32'(CMD_READY), 32'd0);
    RST_n = 1'b0;
    cyc();
    RST_n = 1'b1;
    cyc();
    chk("nr_recover", 32'(CMD_READY), 32'd1);
`endif

    // one more transaction after recovery
    run_vec(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
